// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision field definitions for the integer-to-float path.
package float_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  // Exponent of a value whose leading one sits at bit 31 (bias + 31).
  localparam logic [FP32_EXP_W-1:0] I2F_EXP_BASE = FP32_EXP_W'(FP32_BIAS + 31);

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;

  typedef struct packed {
    logic  zero;
    logic  inexact;
    fp32_t f;
  } i2f_res_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] val_i,
  output logic [5:0]  cnt_o
);

  // Scan from LSB up so the highest set bit wins.
  always_comb begin
    cnt_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (val_i[i]) cnt_o = 6'(31 - i);
    end
  end

endmodule

// File: rtl/int_to_float_pipe.sv
// Three-stage integer to FP32 converter with valid/ready flow control on both sides.
// Stage 1 captures sign/magnitude, stage 2 counts leading zeros, stage 3 normalises,
// rounds and packs. All stages share one advance enable so a stalled output freezes
// the whole pipe.
module int_to_float_pipe
  import float_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1,
  parameter bit ROUND_RNE = 1'b1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iData,
  input  logic        iValid,
  output logic        oReady,
  output logic [31:0] oData,
  output logic        oValid,
  input  logic        iReady,
  output logic        oZero,
  output logic        oInexact
);

  // Round-up decision from guard, sticky and mantissa LSB.
  function automatic logic round_up(input logic g, input logic s, input logic lsb);
    return ROUND_RNE ? (g & (s | lsb)) : 1'b0;
  endfunction

  // Normalise, round and pack one magnitude; a zero magnitude yields +0.0.
  function automatic i2f_res_t convert(input logic sgn, input logic [31:0] mag,
                                       input logic [5:0] lz);
    i2f_res_t        r;
    logic [31:0]     norm;
    logic [22:0]     man;
    logic            g;
    logic            s;
    logic [23:0]     sum;
    logic [7:0]      exp;
    norm = mag << lz;
    exp  = I2F_EXP_BASE - {2'b00, lz};
    man  = norm[30:8];
    g    = norm[7];
    s    = |norm[6:0];
    sum  = {1'b0, man} + {23'd0, round_up(g, s, man[0])};
    if (sum[23]) begin
      man = '0;
      exp = exp + 8'd1;
    end else begin
      man = sum[22:0];
    end
    r.zero      = 1'b0;
    r.inexact   = g | s;
    r.f.sign    = sgn;
    r.f.exp     = exp;
    r.f.man     = man;
    if (mag == 32'd0) begin
      r = '0;
      r.zero = 1'b1;
    end
    return r;
  endfunction

  logic adv;

  logic        vld_p1_q, sign_p1_q;
  logic [31:0] mag_p1_q;
  logic        sign_p1_d;
  logic [31:0] mag_p1_d;

  logic        vld_p2_q, sign_p2_q;
  logic [31:0] mag_p2_q;
  logic [5:0]  lz_p2_q;
  logic [5:0]  lz_p2_d;

  logic        vld_p3_q, zero_p3_q, inexact_p3_q;
  logic [31:0] data_p3_q;
  i2f_res_t    res_p3_d;

  assign adv    = !vld_p3_q | iReady;
  assign oReady = adv;

  // ---- stage 1: sign/magnitude capture ----
  // Two's complement negation maps -2^31 onto 0x80000000, which is still the right magnitude.
  always_comb begin
    sign_p1_d = SIGNED_IN & iData[31];
    mag_p1_d  = sign_p1_d ? (~iData + 32'd1) : iData;
  end

  // ---- stage 2: leading-zero count ----
  lzc32 u_lzc (
    .val_i (mag_p1_q),
    .cnt_o (lz_p2_d)
  );

  // ---- stage 3: normalise, round, pack ----
  // Combinational result that the output register captures.
  always_comb begin
    res_p3_d = convert(sign_p2_q, mag_p2_q, lz_p2_q);
  end

  // Valid bits and output register: cleared asynchronously, advance together.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      vld_p3_q     <= 1'b0;
      data_p3_q    <= '0;
      zero_p3_q    <= 1'b0;
      inexact_p3_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q     <= iValid;
      vld_p2_q     <= vld_p1_q;
      vld_p3_q     <= vld_p2_q;
      data_p3_q    <= res_p3_d.f;
      zero_p3_q    <= res_p3_d.zero;
      inexact_p3_q <= res_p3_d.inexact;
    end
  end

  // Intermediate datapath registers carry no reset; their valid bits qualify them.
  always_ff @(posedge iClk) begin
    if (adv) begin
      sign_p1_q <= sign_p1_d;
      mag_p1_q  <= mag_p1_d;
      sign_p2_q <= sign_p1_q;
      mag_p2_q  <= mag_p1_q;
      lz_p2_q   <= lz_p2_d;
    end
  end

  assign oValid   = vld_p3_q;
  assign oData    = data_p3_q;
  assign oZero    = zero_p3_q;
  assign oInexact = inexact_p3_q;

endmodule
